// File: rtl/dw_lp_multifunc_seq_pkg.sv
// Shared encodings for the sequential RECIP/SQRT/SQUARE unit.
package dw_lp_multifunc_seq_pkg;

  localparam logic [2:0] FUNC_RECIP  = 3'b001;
  localparam logic [2:0] FUNC_SQRT   = 3'b010;
  localparam logic [2:0] FUNC_SQUARE = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ST_INVALID = 0;
  localparam int unsigned ST_EXACT   = 1;

  function automatic logic is_onehot3(input logic [2:0] f);
    return (f == FUNC_RECIP) || (f == FUNC_SQRT) || (f == FUNC_SQUARE);
  endfunction

endpackage

// File: rtl/dw_lp_multifunc_seq_iter.sv
// One recurrence step for RECIP / SQRT / SQUARE around a single shared add/sub.
module dw_lp_multifunc_seq_iter
  import dw_lp_multifunc_seq_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 16
) (
  input  logic [2:0]            mode,
  input  logic                  pad,
  input  logic [OP_WIDTH-1:0]   opa,
  input  logic [OP_WIDTH+1:0]   rem,
  input  logic [OP_WIDTH-1:0]   res,
  input  logic [2*OP_WIDTH-1:0] src,
  input  logic                  sticky,
  output logic [OP_WIDTH+1:0]   rem_n,
  output logic [OP_WIDTH:0]     res_n,
  output logic [2*OP_WIDTH-1:0] src_n,
  output logic                  sticky_n
);

  localparam int unsigned W = OP_WIDTH;

  logic [W+1:0] x;
  logic [W+1:0] y;
  logic         sub;
  logic [W+2:0] sum;
  logic         ge;

  always_comb begin
    x   = '0;
    y   = '0;
    sub = 1'b0;
    if (mode == FUNC_RECIP) begin
      x   = {rem[W:0], src[2*W-1]};
      y   = {2'b00, opa};
      sub = 1'b1;
    end else if (mode == FUNC_SQRT) begin
      x   = {rem[W-1:0], src[2*W-1 -: 2]};
      y   = {res, 2'b01};
      sub = 1'b1;
    end else begin
      x = rem;
      if (src[0]) y = {2'b00, opa};
    end
  end

  // Subtract as x + ~y + 1 over one extra bit; the top bit is the borrow.
  assign sum = {1'b0, x} + ({1'b0, y} ^ {(W+3){sub}}) + {{(W+2){1'b0}}, sub};
  assign ge  = ~sum[W+2];

  always_comb begin
    rem_n    = rem;
    res_n    = {1'b0, res};
    src_n    = src;
    sticky_n = sticky;
    if (!pad) begin
      if (mode == FUNC_SQUARE) begin
        rem_n    = {1'b0, sum[W+1:1]};
        sticky_n = sticky | sum[0];
        src_n    = src >> 1;
      end else begin
        rem_n = ge ? sum[W+1:0] : x;
        res_n = {res, ge};
        src_n = (mode == FUNC_SQRT) ? (src << 2) : (src << 1);
      end
    end
  end

endmodule

// File: rtl/dw_lp_multifunc_seq.sv
// Sequential low-power multifunction unit: one result bit per cycle, valid/ready on both sides.
module dw_lp_multifunc_seq
  import dw_lp_multifunc_seq_pkg::*;
#(
  parameter int unsigned OP_WIDTH    = 16,
  parameter logic [2:0]  FUNC_SELECT = 3'b111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dg_ctrl,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] a,
  input  logic [2:0]          func,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH:0]   z,
  output logic [1:0]          status,
  output logic                busy
);

  localparam int unsigned W    = OP_WIDTH;
  localparam int unsigned CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  state_t state, state_n;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   opa;
  logic [2:0]     fn;
  logic [W+1:0]   rem;
  logic [W-1:0]   res;
  logic [2*W-1:0] src;
  logic           sticky;

  logic [W+1:0]   rem_n;
  logic [W:0]     res_n;
  logic [2*W-1:0] src_n;
  logic           sticky_n;

  logic           accept, step, last, pad;
  logic           in_ok, zero_div;
  logic [2*W-1:0] src_init;
  logic [W:0]     result;
  logic           exact;
  logic [1:0]     st_inv, st_done;

  always_comb begin
    zero_div = (func == FUNC_RECIP) && (a == '0);
    in_ok    = is_onehot3(func) && ((func & FUNC_SELECT) != 3'b000) && !zero_div;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = in_ok ? BUSY : DONE;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && dg_ctrl;
    out_valid = (state == DONE);
    busy      = (state == BUSY) || (state == DONE);
    accept    = in_ready && in_valid;
    step      = (state == BUSY);
    last      = step && (cnt == LAST);
    // SQRT/SQUARE produce W bits; their last iteration is an idle pad.
    pad       = (cnt == LAST) && (fn != FUNC_RECIP);
  end

  always_comb begin
    src_init = '0;
    if (func == FUNC_RECIP)     src_init[2*W-1] = 1'b1;
    else if (func == FUNC_SQRT) src_init = {a, {W{1'b0}}};
    else                        src_init[W-1:0] = a;
  end

  always_comb begin
    if (fn == FUNC_SQUARE) begin
      result = rem_n[W:0];
      exact  = ~sticky_n;
    end else begin
      result = res_n;
      exact  = (rem_n == '0);
    end
    st_inv              = '0;
    st_inv[ST_INVALID]  = 1'b1;
    st_done             = '0;
    st_done[ST_EXACT]   = exact;
  end

  dw_lp_multifunc_seq_iter #(
    .OP_WIDTH(OP_WIDTH)
  ) u_iter (
    .mode    (fn),
    .pad     (pad),
    .opa     (opa),
    .rem     (rem),
    .res     (res),
    .src     (src),
    .sticky  (sticky),
    .rem_n   (rem_n),
    .res_n   (res_n),
    .src_n   (src_n),
    .sticky_n(sticky_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      fn     <= '0;
      rem    <= '0;
      res    <= '0;
      src    <= '0;
      sticky <= 1'b0;
      z      <= '0;
      status <= '0;
    end else if (accept) begin
      cnt    <= '0;
      opa    <= a;
      fn     <= func;
      rem    <= '0;
      res    <= '0;
      src    <= src_init;
      sticky <= 1'b0;
      if (!in_ok) begin
        z      <= {(W+1){zero_div}};
        status <= st_inv;
      end
    end else if (step) begin
      cnt    <= last ? '0 : cnt + CW'(1);
      rem    <= rem_n;
      res    <= res_n[W-1:0];
      src    <= src_n;
      sticky <= sticky_n;
      if (last) begin
        z      <= result;
        status <= st_done;
      end
    end
  end

endmodule

// File: tb/tb_dw_lp_multifunc_seq.sv
module tb_dw_lp_multifunc_seq;
  import dw_lp_multifunc_seq_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst, dg_ctrl, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a;
  logic [2:0]   func;
  logic [W:0]   z;
  logic [1:0]   status;

  logic b_dg, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [W-1:0] b_a;
  logic [2:0]   b_func;
  logic [W:0]   b_z;
  logic [1:0]   b_status;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic [15:0] a;
    logic [2:0]  f;
    logic [16:0] z;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  dw_lp_multifunc_seq #(.OP_WIDTH(W), .FUNC_SELECT(3'b111)) dut (
    .clk(clk), .rst(rst), .dg_ctrl(dg_ctrl), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .func(func), .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .status(status), .busy(busy)
  );

  dw_lp_multifunc_seq #(.OP_WIDTH(W), .FUNC_SELECT(3'b011)) dut_b (
    .clk(clk), .rst(rst), .dg_ctrl(b_dg), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .a(b_a), .func(b_func), .out_valid(b_out_valid), .out_ready(b_out_ready), .z(b_z),
    .status(b_status), .busy(b_busy)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Returns {status, z} from the arithmetic definitions.
  function automatic logic [18:0] model(input logic [15:0] av, input logic [2:0] fv, input logic [2:0] fsel);
    longint unsigned aa, nn, q, r, t;
    logic [1:0] st;
    aa = av;
    if (fv == 3'b001 && av == 16'd0) return {2'b01, 17'h1FFFF};
    if (!(fv == 3'b001 || fv == 3'b010 || fv == 3'b100) || ((fv & fsel) == 3'b000))
      return {2'b01, 17'h0};
    if (fv == 3'b001) begin
      q = 64'd65536 / aa;
      r = 64'd65536 % aa;
    end else if (fv == 3'b010) begin
      nn = aa << 16;
      q  = 0;
      for (int b = 15; b >= 0; b--) begin
        t = q | (64'd1 << b);
        if (t * t <= nn) q = t;
      end
      r = nn - q * q;
    end else begin
      nn = aa * aa;
      q  = nn >> 16;
      r  = nn & 64'hFFFF;
    end
    st = (r == 0) ? 2'b10 : 2'b00;
    return {st, q[16:0]};
  endfunction

  // Starts right after the accepting edge; latency is edges after that edge.
  task automatic finish_op(input logic [16:0] ez, input logic [1:0] es, input int elat,
                           input int hold, input string tag);
    int cnt = 0;
    bit quiet = 1'b1;
    while (out_valid !== 1'b1 && cnt < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, cnt, elat);
    if (elat > 0) check({tag, " busy"}, quiet, 1);
    check({tag, " z"}, z, ez);
    check({tag, " status"}, status, es);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {out_valid, in_ready, busy, z, status}, {1'b1, 1'b0, 1'b1, ez, es});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " release"}, {out_valid, busy, in_ready}, {1'b0, 1'b0, dg_ctrl});
  endtask

  task automatic do_op(input logic [15:0] av, input logic [2:0] fv, input logic [16:0] ez,
                       input logic [1:0] es, input int elat, input int hold, input string tag);
    a = av; func = fv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_op(ez, es, elat, hold, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'd3,     3'b001, 17'd21845,   2'b00, 17};
    vecs[1]  = '{16'd16384, 3'b010, 17'd32768,   2'b10, 17};
    vecs[2]  = '{16'd1,     3'b001, 17'h10000,   2'b10, 17};
    vecs[3]  = '{16'hFFFF,  3'b100, 17'h0FFFE,   2'b00, 17};
    vecs[4]  = '{16'h0100,  3'b100, 17'd1,       2'b10, 17};
    vecs[5]  = '{16'd0,     3'b001, 17'h1FFFF,   2'b01, 0};
    vecs[6]  = '{16'd5,     3'b011, 17'd0,       2'b01, 0};
    vecs[7]  = '{16'd9,     3'b000, 17'd0,       2'b01, 0};
    vecs[8]  = '{16'd4,     3'b010, 17'd512,     2'b10, 17};
    vecs[9]  = '{16'hFFFF,  3'b010, 17'h0FFFF,   2'b00, 17};
    vecs[10] = '{16'hFFFF,  3'b001, 17'd1,       2'b00, 17};
    vecs[11] = '{16'd0,     3'b100, 17'd0,       2'b10, 17};
    vecs[12] = '{16'h8000,  3'b001, 17'd2,       2'b10, 17};
    vecs[13] = '{16'd4,     3'b110, 17'd0,       2'b01, 0};
    vecs[14] = '{16'd0,     3'b010, 17'd0,       2'b10, 17};

    rst = 1'b1; dg_ctrl = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; func = '0;
    b_dg = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_a = '0; b_func = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset", {out_valid, z, status, busy, in_ready}, {1'b0, 17'h0, 2'b00, 1'b0, 1'b1});

    for (int i = 0; i < 15; i++)
      do_op(vecs[i].a, vecs[i].f, vecs[i].z, vecs[i].st, vecs[i].lat, i % 3, $sformatf("vec%0d", i));

    // Backpressure: 65536/7 = 9362 rem 2.
    a = 16'd7; func = FUNC_RECIP; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("bp latency", n, 17);
    for (int i = 0; i < 5; i++) begin
      check("bp hold", {out_valid, in_ready, z, status}, {1'b1, 1'b0, 17'd9362, 2'b00});
      @(posedge clk); #1;
    end
    check("bp hold end", {out_valid, in_ready, z, status}, {1'b1, 1'b0, 17'd9362, 2'b00});
    a = 16'd3; func = FUNC_SQUARE; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp no accept at handshake", {out_valid, busy, in_ready}, 3'b001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp accept next cycle", {busy, in_ready}, 2'b10);
    finish_op(17'd0, 2'b00, 17, 0, "bp square");

    // Gating blocks accepts only.
    dg_ctrl = 1'b0; a = 16'd5; func = FUNC_RECIP; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("dg block", {busy, in_ready, out_valid}, 3'b000);
    end
    in_valid = 1'b0; dg_ctrl = 1'b1;
    @(posedge clk); #1;
    a = 16'd4; func = FUNC_SQRT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 dg_ctrl = 1'b0;
    finish_op(17'd512, 2'b10, 12, 1, "dg drop sqrt");
    dg_ctrl = 1'b1;

    // Reset mid-op discards it.
    a = 16'd3; func = FUNC_RECIP; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid-op", {out_valid, z, status, busy, in_ready}, {1'b0, 17'h0, 2'b00, 1'b0, 1'b1});
    do_op(16'd5, FUNC_RECIP, 17'd13107, 2'b00, 17, 0, "after rst");

    for (int k = 0; k < 40; k++) begin
      logic [15:0] av;
      logic [2:0]  fv;
      logic [18:0] e;
      int sel;
      sel = $urandom_range(0, 9);
      fv  = (sel < 3) ? FUNC_RECIP : (sel < 6) ? FUNC_SQRT : (sel < 9) ? FUNC_SQUARE : 3'($urandom);
      av  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      e   = model(av, fv, 3'b111);
      do_op(av, fv, e[16:0], e[18:17], e[17] ? 0 : 17, $urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    // Build without SQUARE.
    b_a = 16'h0100; b_func = FUNC_SQUARE; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check("fsel011 square", {b_out_valid, b_busy, b_z, b_status}, {1'b1, 1'b1, 17'h0, 2'b01});
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("fsel011 release", {b_out_valid, b_in_ready}, 2'b01);
    b_a = 16'd16384; b_func = FUNC_SQRT; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("fsel011 sqrt latency", n, 17);
    check("fsel011 sqrt", {b_z, b_status}, {17'd32768, 2'b10});
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
